// File: rtl/mux_4_to_1_rr_ctrl.sv
// Round-robin arbiter and sequencer for a shared 4:1 mux with bounded-burst tenures.
// The owner's word is presented combinationally with a valid/ready handshake.
module mux_4_to_1_rr_ctrl #(
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] req_data,
  input  logic            out_ready,
  output logic [1:0]      sel,
  output logic [3:0]      gnt,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [3:0]      ack,
  output logic            busy
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LastBeat = CW'(MAX_BURST - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e        r_state;
  logic [1:0]    r_sel;
  logic [3:0]    r_gnt;
  logic [1:0]    r_last;
  logic [CW-1:0] r_burst_cnt;

  logic [1:0] w_winner;
  logic [1:0] w_idx;
  logic       w_found;
  logic       w_xfer;

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    w_winner = 2'd0;
    w_idx    = 2'd0;
    w_found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_last + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid = (r_state == StBusy) && req[r_sel];
    out_data  = req_data[32'(r_sel) * DW +: DW];
    w_xfer    = out_valid && out_ready;
    ack       = w_xfer ? (4'b0001 << r_sel) : 4'b0000;
    busy      = (r_state == StBusy);
    sel       = r_sel;
    gnt       = r_gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_sel       <= 2'd0;
      r_gnt       <= 4'b0000;
      r_last      <= 2'd3;
      r_burst_cnt <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_sel       <= w_winner;
            r_gnt       <= 4'b0001 << w_winner;
            r_burst_cnt <= '0;
            r_state     <= StBusy;
          end
        end
        StBusy: begin
          if (!req[r_sel]) begin
            r_state     <= StIdle;
            r_last      <= r_sel;
            r_gnt       <= 4'b0000;
            r_burst_cnt <= '0;
          end else if (w_xfer && (r_burst_cnt == LastBeat)) begin
            r_state     <= StIdle;
            r_last      <= r_sel;
            r_gnt       <= 4'b0000;
            r_burst_cnt <= '0;
          end else if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + CW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_4_to_1_rr_ctrl.sv
// Directed bench: three instances (MAX_BURST 4, 2, 1) share stimulus; each test
// resets all of them and checks the instance whose burst limit it targets.
module tb_mux_4_to_1_rr_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        out_ready;

  logic [1:0] sel4, sel2, sel1;
  logic [3:0] gnt4, gnt2, gnt1;
  logic       ov4, ov2, ov1;
  logic [7:0] data4, data2, data1;
  logic [3:0] ack4, ack2, ack1;
  logic       busy4, busy2, busy1;

  int n_checks;
  int n_fail;

  mux_4_to_1_rr_ctrl #(.DW(8), .MAX_BURST(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .out_ready(out_ready),
    .sel(sel4), .gnt(gnt4), .out_valid(ov4), .out_data(data4), .ack(ack4), .busy(busy4)
  );

  mux_4_to_1_rr_ctrl #(.DW(8), .MAX_BURST(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .out_ready(out_ready),
    .sel(sel2), .gnt(gnt2), .out_valid(ov2), .out_data(data2), .ack(ack2), .busy(busy2)
  );

  mux_4_to_1_rr_ctrl #(.DW(8), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .out_ready(out_ready),
    .sel(sel1), .gnt(gnt1), .out_valid(ov1), .out_data(data1), .ack(ack1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if ({sel4, gnt4, ov4, ack4, busy4} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_dut4: got sel=%0d gnt=%b ov=%b ack=%b busy=%b, want all zero",
               sel4, gnt4, ov4, ack4, busy4);
    end
    n_checks++;
    if ({sel2, gnt2, ov2, ack2, busy2, sel1, gnt1, ov1, ack1, busy1} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_dut2_dut1: got gnt2=%b ov2=%b gnt1=%b ov1=%b, want zero",
               gnt2, ov2, gnt1, ov1);
    end
  endtask

  task automatic test_single();
    do_reset();
    req       = 4'b0001;
    out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      #1;
      n_checks++;
      if (ov4 !== 1'b0 || busy4 !== 1'b0 || gnt4 !== 4'b0000) begin
        n_fail++;
        $display("FAIL single_bubble t%0d: got ov=%b busy=%b gnt=%b, want 0 0 0000",
                 t, ov4, busy4, gnt4);
      end
      step();
      for (int k = 0; k < 4; k++) begin
        #1;
        n_checks++;
        if (sel4 !== 2'd0 || gnt4 !== 4'b0001 || ov4 !== 1'b1 || ack4 !== 4'b0001 ||
            data4 !== 8'hA0) begin
          n_fail++;
          $display("FAIL single_xfer t%0d k%0d: got sel=%0d gnt=%b ov=%b ack=%b data=%h, want 0 0001 1 0001 a0",
                   t, k, sel4, gnt4, ov4, ack4, data4);
        end
        step();
      end
    end
  endtask

  task automatic test_all_rr();
    logic [1:0] order [5];
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req       = 4'b1111;
    out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      exp_g = 4'b0001 << order[t];
      exp_d = 8'hA0 | {6'd0, order[t]};
      #1;
      n_checks++;
      if (ov2 !== 1'b0 || gnt2 !== 4'b0000) begin
        n_fail++;
        $display("FAIL rr_bubble t%0d: got ov=%b gnt=%b, want 0 0000", t, ov2, gnt2);
      end
      step();
      for (int k = 0; k < 2; k++) begin
        #1;
        n_checks++;
        if (sel2 !== order[t] || gnt2 !== exp_g || ov2 !== 1'b1 || ack2 !== exp_g ||
            data2 !== exp_d) begin
          n_fail++;
          $display("FAIL rr_xfer t%0d k%0d: got sel=%0d gnt=%b ov=%b ack=%b data=%h, want %0d %b 1 %b %h",
                   t, k, sel2, gnt2, ov2, ack2, data2, order[t], exp_g, exp_g, exp_d);
        end
        step();
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] ready_seq;
    do_reset();
    req       = 4'b0100;
    out_ready = 1'b0;
    step();
    ready_seq = 3'b100;
    for (int c = 0; c < 3; c++) begin
      out_ready = ready_seq[c];
      #1;
      n_checks++;
      if (sel4 !== 2'd2 || ov4 !== 1'b1 || data4 !== 8'hA2 ||
          ack4 !== (ready_seq[c] ? 4'b0100 : 4'b0000)) begin
        n_fail++;
        $display("FAIL bp_stall c%0d: got sel=%0d ov=%b data=%h ack=%b, want 2 1 a2 %b",
                 c, sel4, ov4, data4, ack4, ready_seq[c] ? 4'b0100 : 4'b0000);
      end
      step();
    end
    // Stalls must not consume burst slots: three more beats before the bubble.
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (ov4 !== 1'b1 || ack4 !== 4'b0100) begin
        n_fail++;
        $display("FAIL bp_rest c%0d: got ov=%b ack=%b, want 1 0100", c, ov4, ack4);
      end
      step();
    end
    #1;
    n_checks++;
    if (ov4 !== 1'b0 || busy4 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_end_bubble: got ov=%b busy=%b, want 0 0", ov4, busy4);
    end
  endtask

  task automatic test_abandon();
    do_reset();
    req       = 4'b1010;
    out_ready = 1'b1;
    step();
    #1;
    n_checks++;
    if (sel4 !== 2'd1 || gnt4 !== 4'b0010 || ack4 !== 4'b0010) begin
      n_fail++;
      $display("FAIL abandon_first: got sel=%0d gnt=%b ack=%b, want 1 0010 0010",
               sel4, gnt4, ack4);
    end
    step();
    req = 4'b1000;
    #1;
    n_checks++;
    if (ov4 !== 1'b0 || ack4 !== 4'b0000) begin
      n_fail++;
      $display("FAIL abandon_drop: got ov=%b ack=%b, want 0 0000", ov4, ack4);
    end
    step();
    req = 4'b1010;
    #1;
    n_checks++;
    if (busy4 !== 1'b0 || gnt4 !== 4'b0000 || ov4 !== 1'b0) begin
      n_fail++;
      $display("FAIL abandon_idle: got busy=%b gnt=%b ov=%b, want 0 0000 0", busy4, gnt4, ov4);
    end
    step();
    #1;
    n_checks++;
    if (sel4 !== 2'd3 || gnt4 !== 4'b1000 || ack4 !== 4'b1000 || data4 !== 8'hA3) begin
      n_fail++;
      $display("FAIL abandon_next: got sel=%0d gnt=%b ack=%b data=%h, want 3 1000 1000 a3",
               sel4, gnt4, ack4, data4);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req       = 4'b1111;
    out_ready = 1'b1;
    step();
    step();
    step();
    step();
    #1;
    n_checks++;
    if (sel2 !== 2'd1 || gnt2 !== 4'b0010 || ov2 !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: got sel=%0d gnt=%b ov=%b, want 1 0010 1", sel2, gnt2, ov2);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (sel2 !== 2'd0 || gnt2 !== 4'b0000 || ov2 !== 1'b0 || ack2 !== 4'b0000 ||
        busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got sel=%0d gnt=%b ov=%b ack=%b busy=%b, want 0 0000 0 0000 0",
               sel2, gnt2, ov2, ack2, busy2);
    end
    step();
    rst_n = 1'b1;
    step();
    #1;
    n_checks++;
    if (sel2 !== 2'd0 || gnt2 !== 4'b0001 || ack2 !== 4'b0001) begin
      n_fail++;
      $display("FAIL midrst_regrant: got sel=%0d gnt=%b ack=%b, want 0 0001 0001",
               sel2, gnt2, ack2);
    end
  endtask

  task automatic test_burst1();
    logic [3:0] exp_g;
    do_reset();
    req       = 4'b0011;
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 0) ? 4'b0001 : 4'b0010;
      #1;
      n_checks++;
      if (ov1 !== 1'b0 || busy1 !== 1'b0) begin
        n_fail++;
        $display("FAIL mb1_bubble t%0d: got ov=%b busy=%b, want 0 0", t, ov1, busy1);
      end
      step();
      #1;
      n_checks++;
      if (gnt1 !== exp_g || ack1 !== exp_g || ov1 !== 1'b1) begin
        n_fail++;
        $display("FAIL mb1_xfer t%0d: got gnt=%b ack=%b ov=%b, want %b %b 1",
                 t, gnt1, ack1, ov1, exp_g, exp_g);
      end
      step();
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req       = 4'b0000;
    out_ready = 1'b0;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    test_reset();
    test_single();
    test_all_rr();
    test_backpressure();
    test_abandon();
    test_reset_mid();
    test_burst1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
